// File: rtl/uart_rx_pkg.sv
// Shared definitions for the serial receive path: FSM state encodings, byte width
// and the serial data/status port addresses also decoded by mem_control.
`timescale 1ns/1ps
package uart_rx_pkg;
  localparam int BYTE_W = 8;
  localparam logic [15:0] SERIAL_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] SERIAL_STAT_ADDR = 16'hBF01;

  typedef enum logic [2:0] {
    RxIdle,
    RxReq,
    RxSetup,
    RxStrobe,
    RxRelease,
    RxWaitDr
  } rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: DEPTH entries (power of two), head read combinationally
// from registered storage, pointers wrap naturally, pop on empty is ignored.
`timescale 1ns/1ps
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [BYTE_W-1:0]        push_data,
  input  logic                     pop,
  output logic [BYTE_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              pop_ok;

  assign pop_ok = pop && (count_reg != '0);
  assign head   = mem_reg[rd_ptr_reg];
  assign count  = count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // The controller never pushes into a full buffer, so no overflow guard here.
      count_reg <= count_reg + CW'(push) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/uart_rx.sv
// Serial chip receive controller: polls data_ready, arbitrates for ram1data, strobes
// rdn and buffers the byte. Define UART_RX_FIFO_EN for the FIFO; else one holding register.
`timescale 1ns/1ps
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int SETUP_CYCLES   = 1,
  parameter int RDN_LOW_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_ready,
  input  logic [BYTE_W-1:0]            ram1_data_i,
  output logic                         rdn,
  output logic                         bus_req_o,
  input  logic                         bus_gnt_i,
  output logic [BYTE_W-1:0]            rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_pop_i,
  output logic [$clog2(FIFO_DEPTH):0]  rx_count_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] LOW_LAST   = 8'(RDN_LOW_CYCLES - 1);

  rx_state_t state_reg;
  logic [7:0] cnt_reg;
  logic       rdn_reg;
  logic       bus_req_reg;
  logic       dr_meta_reg;
  logic       dr_s;
  logic       push;
  logic       full;

  assign rdn       = rdn_reg;
  assign bus_req_o = bus_req_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr_meta_reg <= 1'b0;
      dr_s        <= 1'b0;
    end else begin
      dr_meta_reg <= data_ready;
      dr_s        <= dr_meta_reg;
    end
  end

  // Capture happens on the edge that ends the last low cycle, and only with grant held.
  assign push = (state_reg == RxStrobe) && bus_gnt_i && (cnt_reg == LOW_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RxIdle;
      cnt_reg     <= '0;
      rdn_reg     <= 1'b1;
      bus_req_reg <= 1'b0;
    end else begin
      case (state_reg)
        RxIdle: begin
          if (dr_s && !full) begin
            state_reg   <= RxReq;
            bus_req_reg <= 1'b1;
          end
        end
        RxReq: begin
          if (bus_gnt_i) begin
            cnt_reg <= '0;
            if (SETUP_CYCLES == 0) begin
              state_reg <= RxStrobe;
              rdn_reg   <= 1'b0;
            end else begin
              state_reg <= RxSetup;
            end
          end
        end
        RxSetup: begin
          if (!bus_gnt_i) begin
            state_reg <= RxReq;
          end else if (cnt_reg == SETUP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= RxStrobe;
            rdn_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RxStrobe: begin
          if (!bus_gnt_i) begin
            rdn_reg   <= 1'b1;
            state_reg <= RxReq;
          end else if (cnt_reg == LOW_LAST) begin
            rdn_reg   <= 1'b1;
            state_reg <= RxRelease;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RxRelease: begin
          bus_req_reg <= 1'b0;
          state_reg   <= RxWaitDr;
        end
        RxWaitDr: begin
          // Wait for the chip to drop data_ready so the same byte is not read twice.
          if (!dr_s) state_reg <= RxIdle;
        end
        default: begin
          state_reg   <= RxIdle;
          rdn_reg     <= 1'b1;
          bus_req_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ram1_data_i),
    .pop       (rx_pop_i),
    .head      (rx_data_o),
    .count     (rx_count_o)
  );

  assign rx_valid_o = (rx_count_o != '0);
  assign full       = (rx_count_o == CW'(FIFO_DEPTH));
`else
  logic              hold_valid_reg;
  logic [BYTE_W-1:0] hold_data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (push) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= ram1_data_i;
    end else if (rx_pop_i) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign rx_data_o  = hold_data_reg;
  assign rx_valid_o = hold_valid_reg;
  assign rx_count_o = CW'(hold_valid_reg);
  assign full       = hold_valid_reg;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes go into a scoreboard queue, a monitor
// compares them whenever the DUT pops; strobe shape and counts are checked inline.
`timescale 1ns/1ps
module tb_uart_rx;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] ram1_data_i = 8'h00;
  logic       rdn;
  logic       bus_req_o;
  logic       bus_gnt_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_pop_i = 1'b0;
  logic [2:0] rx_count_o;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];
  bit   gnt_auto = 1'b1;
  int   strobes  = 0;
  int   low_len  = 0;
  int   last_low = 0;
  logic prev_rdn = 1'b1;

  uart_rx #(
    .FIFO_DEPTH     (4),
    .SETUP_CYCLES   (1),
    .RDN_LOW_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_ready  (data_ready),
    .ram1_data_i (ram1_data_i),
    .rdn         (rdn),
    .bus_req_o   (bus_req_o),
    .bus_gnt_i   (bus_gnt_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_pop_i    (rx_pop_i),
    .rx_count_o  (rx_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Monitor: strobe shape and scoreboard comparison of popped bytes.
  initial begin
    forever begin
      @(negedge clk);
      if (rdn === 1'b0) begin
        if (prev_rdn === 1'b1) strobes++;
        low_len++;
      end else if (prev_rdn === 1'b0) begin
        last_low = low_len;
        low_len  = 0;
      end
      prev_rdn = rdn;
      if (rx_pop_i && rx_valid_o) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", int'(rx_data_o), -1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("pop: data=0x%02h expected=0x%02h", rx_data_o, e);
          check("pop_data", int'(rx_data_o), int'(e));
        end
      end
    end
  end

  // Bus arbiter stand-in: grants one cycle after the request unless disabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (gnt_auto) bus_gnt_i = bus_req_o;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdn_low(input string name);
    for (int i = 0; i < 60; i++) begin
      if (rdn === 1'b0) return;
      tick();
    end
    check({name, "_rdn_timeout"}, 0, 1);
  endtask

  task automatic wait_bus_req(input string name);
    for (int i = 0; i < 60; i++) begin
      if (bus_req_o === 1'b1) return;
      tick();
    end
    check({name, "_req_timeout"}, 0, 1);
  endtask

  task automatic deliver(input logic [7:0] b);
    ram1_data_i = b;
    data_ready  = 1'b1;
    wait_rdn_low("deliver");
    tick();
    data_ready = 1'b0;
    exp_q.push_back(b);
    repeat (8) tick();
  endtask

  task automatic pop1();
    rx_pop_i = 1'b1;
    tick();
    rx_pop_i = 1'b0;
    tick();
  endtask

  initial begin
    int s0;
    // Reset state
    repeat (3) tick();
    check("rst_rdn", int'(rdn), 1);
    check("rst_req", int'(bus_req_o), 0);
    check("rst_valid", int'(rx_valid_o), 0);
    check("rst_count", int'(rx_count_o), 0);
    check("rst_data", int'(rx_data_o), 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", int'({rdn, bus_req_o, rx_valid_o}), 3'b100);
    end

    // Single byte, with request latency and strobe width
    s0 = strobes;
    ram1_data_i = 8'h5A;
    data_ready  = 1'b1;
    tick(); tick();
    check("req_latency_early", int'(bus_req_o), 0);
    tick();
    check("req_latency", int'(bus_req_o), 1);
    wait_rdn_low("single");
    tick();
    data_ready = 1'b0;
    exp_q.push_back(8'h5A);
    repeat (8) tick();
    check("single_low_len", last_low, 2);
    check("single_strobes", strobes - s0, 1);
    check("single_valid", int'(rx_valid_o), 1);
    check("single_data", int'(rx_data_o), 8'h5A);
    check("single_count", int'(rx_count_o), 1);
    check("single_req_idle", int'(bus_req_o), 0);
    pop1();
    check("single_empty", int'(rx_count_o), 0);

    // Pop on empty is a no-op
    pop1();
    check("empty_pop_count", int'(rx_count_o), 0);
    check("empty_pop_valid", int'(rx_valid_o), 0);

    // Fill until full; the next read must not start until a pop frees a slot
    for (int i = 1; i <= CAP; i++) deliver(8'(i));
    check("fill_count", int'(rx_count_o), CAP);
    s0 = strobes;
    ram1_data_i = 8'(CAP + 1);
    data_ready  = 1'b1;
    repeat (20) tick();
    check("full_no_strobe", strobes - s0, 0);
    check("full_rdn_high", int'(rdn), 1);
    check("full_no_req", int'(bus_req_o), 0);
    exp_q.push_back(8'(CAP + 1));
    pop1();
    wait_rdn_low("fill_resume");
    tick();
    data_ready = 1'b0;
    repeat (8) tick();
    check("refill_count", int'(rx_count_o), CAP);
    for (int i = 0; i < CAP; i++) pop1();
    check("drain_count", int'(rx_count_o), 0);

    // Grant withheld for 10 cycles
    gnt_auto = 1'b0;
    bus_gnt_i = 1'b0;
    s0 = strobes;
    ram1_data_i = 8'h3C;
    data_ready  = 1'b1;
    wait_bus_req("withheld");
    repeat (10) tick();
    check("withheld_rdn", int'(rdn), 1);
    check("withheld_strobes", strobes - s0, 0);
    bus_gnt_i = 1'b1;
    wait_rdn_low("withheld");
    tick();
    data_ready = 1'b0;
    exp_q.push_back(8'h3C);
    repeat (8) tick();
    check("withheld_count", int'(rx_count_o), 1);
    pop1();

    // Grant dropped during the strobe: abort, re-request, capture once
    bus_gnt_i = 1'b0;
    s0 = strobes;
    ram1_data_i = 8'hC3;
    data_ready  = 1'b1;
    wait_bus_req("loss");
    bus_gnt_i = 1'b1;
    wait_rdn_low("loss");
    bus_gnt_i = 1'b0;
    tick();
    check("loss_rdn_high", int'(rdn), 1);
    check("loss_no_push", int'(rx_count_o), 0);
    check("loss_rereq", int'(bus_req_o), 1);
    repeat (3) tick();
    bus_gnt_i = 1'b1;
    gnt_auto  = 1'b1;
    wait_rdn_low("loss_regrant");
    tick();
    data_ready = 1'b0;
    exp_q.push_back(8'hC3);
    repeat (8) tick();
    check("loss_strobes", strobes - s0, 2);
    check("loss_count", int'(rx_count_o), 1);
    pop1();

`ifdef UART_RX_FIFO_EN
    // Push and pop on the same edge
    deliver(8'h11);
    deliver(8'h22);
    ram1_data_i = 8'h77;
    data_ready  = 1'b1;
    wait_rdn_low("simul");
    tick();
    data_ready = 1'b0;
    rx_pop_i   = 1'b1;
    exp_q.push_back(8'h77);
    tick();
    rx_pop_i = 1'b0;
    tick();
    check("simul_count", int'(rx_count_o), 2);
    pop1();
    pop1();
    check("simul_drain", int'(rx_count_o), 0);
`endif

    // Reset in the middle of a read
    ram1_data_i = 8'h99;
    data_ready  = 1'b1;
    wait_rdn_low("midrst");
    rst = 1'b0;
    #1;
    check("midrst_rdn", int'(rdn), 1);
    check("midrst_req", int'(bus_req_o), 0);
    data_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    check("midrst_count", int'(rx_count_o), 0);
    check("midrst_valid", int'(rx_valid_o), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
